// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding and default sizes for instr_fetch_unit
package ifu_pkg;
  localparam int IFU_INSTR_W = 13;
  localparam int IFU_DEPTH = 16;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, HALT = 2'b11} ifu_state_t;
endpackage

// File: rtl/ifu_imem.sv
// ifu_imem: DEPTH x INSTR_W program memory, one write port and one registered read port.
// Only the read register is reset; the array keeps its contents across reset.
module ifu_imem import ifu_pkg::*; #(
  parameter int INSTR_W = IFU_INSTR_W,
  parameter int DEPTH = IFU_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  assign o_rdata = r_rdata;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loads a program into ifu_imem and fetches it with branch, stall and halt control.
// Define IFU_BOUNDS_TRAP_EN to halt with trap on an out-of-range fetch instead of wrapping to 0.
module instr_fetch_unit import ifu_pkg::*; #(
  parameter int INSTR_W = IFU_INSTR_W,
  parameter int DEPTH = IFU_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               clear,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         state,
  output logic [ADDR_W:0]    prog_len,
  output logic               trap
);
`ifdef IFU_BOUNDS_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  ifu_state_t r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, r_wr_ptr, w_fetch, w_raddr;
  logic [ADDR_W:0] r_prog_len, w_next;
  logic r_valid, r_trap;
  logic w_ready, w_start_go, w_accept, w_load_done, w_advance, w_oob, w_trap_hit, w_fetch_re;
  assign w_ready = (r_state == IDLE) || (r_state == LOAD);
  assign w_start_go = start && !clear && ((r_state == IDLE && r_prog_len != '0) || r_state == HALT);
  assign w_accept = load_valid && w_ready && !clear && !w_start_go;
  assign w_load_done = w_accept && (load_last || r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_advance = (r_state == RUN) && !clear && !halt_req && !stall;
  // one extra bit so pc+1 past the last word is still seen as out of range
  assign w_next = br_valid ? {1'b0, br_target} : {1'b0, r_pc} + (ADDR_W + 1)'(1);
  assign w_oob = w_next >= r_prog_len;
  assign w_trap_hit = TRAP_EN && w_advance && w_oob;
  assign w_fetch = w_oob ? '0 : w_next[ADDR_W-1:0];
  assign w_raddr = w_start_go ? '0 : w_fetch;
  assign w_fetch_re = w_start_go || (w_advance && !w_trap_hit);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_nx;
  always_comb
    w_state_nx = clear ? IDLE :
                 w_start_go ? RUN :
                 w_load_done ? IDLE :
                 w_accept ? LOAD :
                 (r_state == RUN && (halt_req || w_trap_hit)) ? HALT : r_state;
  always_comb begin
    load_ready = w_ready;
    state = r_state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pc <= '0;
      r_wr_ptr <= '0;
      r_prog_len <= '0;
      r_valid <= 1'b0;
      r_trap <= 1'b0;
    end else if (clear) begin
      r_pc <= '0;
      r_wr_ptr <= '0;
      r_prog_len <= '0;
      r_valid <= 1'b0;
      r_trap <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= w_load_done ? '0 : r_wr_ptr + ADDR_W'(1);
      if (w_load_done) r_prog_len <= {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
      if (w_start_go) begin
        r_pc <= '0;
        r_valid <= 1'b1;
        r_trap <= 1'b0;
      end else if (r_state == RUN && halt_req) begin
        r_valid <= 1'b0;
      end else if (w_trap_hit) begin
        r_valid <= 1'b0;
        r_trap <= 1'b1;
      end else if (w_advance) begin
        r_pc <= w_fetch;
      end
    end
  ifu_imem #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_imem (
    .clk(clk),
    .reset(reset),
    .i_we(w_accept),
    .i_waddr(r_wr_ptr),
    .i_wdata(load_data),
    .i_re(w_fetch_re),
    .i_raddr(w_raddr),
    .o_rdata(instr)
  );
  assign instr_valid = r_valid;
  assign pc = r_pc;
  assign prog_len = r_prog_len;
  assign trap = TRAP_EN && r_trap;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_instr_fetch_unit;
  localparam int IW = 13;
  localparam int D = 16;
  localparam int AW = 4;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_HALT = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_valid, load_last, load_ready, start, clear, stall, br_valid, halt_req;
  logic [IW-1:0] load_data, instr;
  logic [AW-1:0] br_target, pc;
  logic instr_valid, trap;
  logic [1:0] state;
  logic [AW:0] prog_len;
  int tests = 0;
  int fails = 0;
  int m_state = 0, m_pc = 0, m_wp = 0, m_plen = 0, m_valid = 0, m_trap = 0, m_nx = 0;
  logic [IW-1:0] m_instr = '0;
  logic [IW-1:0] m_mem [D];
  logic [IW-1:0] prog [6] = '{13'h0800, 13'h0891, 13'h0914, 13'h1420, 13'h0002, 13'h1003};

  instr_fetch_unit dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .start(start), .clear(clear), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .halt_req(halt_req), .instr(instr), .instr_valid(instr_valid), .pc(pc), .state(state),
    .prog_len(prog_len), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference behaviour: one step of the program-load / fetch rules per rising edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = S_IDLE; m_pc = 0; m_wp = 0; m_plen = 0; m_valid = 0; m_trap = 0; m_instr = '0;
    end else if (clear) begin
      m_state = S_IDLE; m_pc = 0; m_wp = 0; m_plen = 0; m_valid = 0; m_trap = 0;
    end else if (start && ((m_state == S_IDLE && m_plen > 0) || m_state == S_HALT)) begin
      m_state = S_RUN; m_pc = 0; m_instr = m_mem[0]; m_valid = 1; m_trap = 0;
    end else if (m_state <= S_LOAD && load_valid) begin
      m_mem[m_wp] = load_data;
      if (load_last || m_wp == D - 1) begin
        m_plen = m_wp + 1; m_wp = 0; m_state = S_IDLE;
      end else begin
        m_wp++; m_state = S_LOAD;
      end
    end else if (m_state == S_RUN) begin
      if (halt_req) begin
        m_state = S_HALT; m_valid = 0;
      end else if (!stall) begin
        m_nx = br_valid ? int'(br_target) : m_pc + 1;
        if (m_nx >= m_plen) begin
`ifdef IFU_BOUNDS_TRAP_EN
          m_state = S_HALT; m_trap = 1; m_valid = 0; m_nx = -1;
`else
          m_nx = 0;
`endif
        end
        if (m_nx >= 0) begin
          m_pc = m_nx; m_instr = m_mem[m_nx];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("pc", 32'(pc), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("prog_len", 32'(prog_len), 32'(m_plen));
    chk("trap", 32'(trap), 32'(m_trap));
    chk("load_ready", 32'(load_ready), 32'(m_state <= S_LOAD));
    chk("instr", 32'(instr), 32'(m_instr));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    load_valid = 0; load_last = 0; load_data = '0; start = 0; clear = 0;
    stall = 0; br_valid = 0; br_target = '0; halt_req = 0;
  endtask

  task automatic load_word(input logic [IW-1:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask

  initial begin
    int len;
    idle_in();
    repeat (2) tick();
    reset = 1;
    tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_plen", 32'(prog_len), 0);
    for (int i = 0; i < D; i++) begin
      load_word(IW'(i * 7 + 3), 1'b0);
      if (i == 0) chk("first_word_load", 32'(state), S_LOAD);
    end
    chk("full_plen", 32'(prog_len), 16);
    chk("full_state", 32'(state), S_IDLE);
    chk("full_ready", 32'(load_ready), 1);
    for (int i = 0; i < 6; i++) load_word(prog[i], i == 5);
    chk("plen6", 32'(prog_len), 6);
    start = 1; tick(); start = 0;
    chk("pc0", 32'(pc), 0);
    chk("instr0", 32'(instr), 32'h0800);
    chk("valid0", 32'(instr_valid), 1);
    tick();
    chk("pc1", 32'(pc), 1);
    chk("instr1", 32'(instr), 32'h0891);
    tick();
    chk("pc2", 32'(pc), 2);
    chk("instr2", 32'(instr), 32'h0914);
    repeat (3) tick();
    chk("pc5", 32'(pc), 5);
    chk("instr5", 32'(instr), 32'h1003);
    br_valid = 1; br_target = 3; tick(); br_valid = 0;
    chk("br_pc", 32'(pc), 3);
    chk("br_instr", 32'(instr), 32'h1420);
    stall = 1; br_valid = 1; br_target = 1;
    repeat (3) begin
      tick();
      chk("stall_pc", 32'(pc), 3);
      chk("stall_instr", 32'(instr), 32'h1420);
    end
    stall = 0; br_valid = 0;
    repeat (2) tick();
    chk("pc5b", 32'(pc), 5);
    tick();
`ifdef IFU_BOUNDS_TRAP_EN
    chk("oob_state", 32'(state), S_HALT);
    chk("oob_trap", 32'(trap), 1);
    chk("oob_valid", 32'(instr_valid), 0);
    chk("oob_pc", 32'(pc), 5);
`else
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_instr", 32'(instr), 32'h0800);
    chk("wrap_state", 32'(state), S_RUN);
`endif
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_state", 32'(state), S_HALT);
    start = 1; tick(); start = 0;
    chk("restart_state", 32'(state), S_RUN);
    chk("restart_pc", 32'(pc), 0);
    tick();
    chk("restart_pc1", 32'(pc), 1);
    halt_req = 1; br_valid = 1; br_target = 4; tick(); halt_req = 0; br_valid = 0;
    chk("halt_br_state", 32'(state), S_HALT);
    chk("halt_br_pc", 32'(pc), 1);
    chk("halt_br_valid", 32'(instr_valid), 0);
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    chk("clear_state", 32'(state), S_IDLE);
    chk("clear_plen", 32'(prog_len), 0);
    chk("clear_pc", 32'(pc), 0);
    load_word(13'h0111, 1'b0);
    load_word(13'h0222, 1'b0);
    load_word(13'h0333, 1'b0);
    chk("midload_state", 32'(state), S_LOAD);
    reset = 0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_plen", 32'(prog_len), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_trap", 32'(trap), 0);
    #1 reset = 1;
    tick();
    start = 1; tick(); start = 0;
    chk("start_ignored", 32'(state), S_IDLE);
    len = $urandom_range(2, D);
    for (int i = 0; i < len; i++) load_word(IW'($urandom), i == len - 1);
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      load_valid = !start && ($urandom_range(0, 9) < 4);
      load_data = IW'($urandom);
      load_last = ($urandom_range(0, 4) == 0);
      clear = ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 4) == 0);
      br_valid = ($urandom_range(0, 4) == 0);
      br_target = AW'($urandom);
      halt_req = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle_in();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
